// File: rtl/ctr_phase_sequencer_pkg.sv
// Shared definitions for the counter phase sequencer: FSM states,
// milestone event numbering and the default milestone thresholds.
package ctr_phase_sequencer_pkg;

    typedef enum logic [2:0] {
        S_START,
        S_WAIT_A,
        S_WAIT_B,
        S_SKIP,
        S_DONE,
        S_ERR
    } seq_state_t;

    // Default bench configuration
    localparam int DEF_CNT_W  = 32;
    localparam int DEF_THR_A  = 2;
    localparam int DEF_THR_B  = 10;
    localparam int DEF_ROUNDS = 2;

    // Event numbering: the start event is 1. Each round then contributes
    // two events, A first and B second.
    localparam logic [3:0] EVT_START = 4'd1;
    localparam logic [3:0] EVT_A_OFS = 4'd0;
    localparam logic [3:0] EVT_B_OFS = 4'd1;

    // Event number of a milestone in a round.
    // For milestone A this is 2 + 2*round; for milestone B it is 3 + 2*round.
    function automatic logic [3:0] milestoneId(input logic [2:0] rnd, input logic [3:0] ofs);
        return EVT_START + 4'd1 + {rnd, 1'b0} + ofs;
    endfunction

endpackage

// File: rtl/ctr_phase_sequencer.sv
// Watches a free-running counter and walks through the milestone sequence
// start -> A -> B(+clear) for a fixed number of rounds. It emits numbered
// one-cycle event pulses, requests counter clears, and flags an error when
// a milestone value is jumped over.
module ctr_phase_sequencer
    import ctr_phase_sequencer_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int THR_A  = DEF_THR_A,
    parameter int THR_B  = DEF_THR_B,
    parameter int ROUNDS = DEF_ROUNDS
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [CNT_W-1:0] i_ctr_in,
    output logic             o_ctr_clr,
    output logic             o_evt,
    output logic [3:0]       o_evt_id,
    output logic [2:0]       o_round,
    output logic             o_done,
    output logic             o_err
);

    localparam logic [CNT_W-1:0] L_THR_A      = CNT_W'(THR_A);
    localparam logic [CNT_W-1:0] L_THR_B      = CNT_W'(THR_B);
    localparam logic [2:0]       L_LAST_ROUND = 3'(ROUNDS - 1);

    seq_state_t       r_state;
    logic             r_ctr_clr;
    logic             r_evt;
    logic [3:0]       r_evt_id;
    logic [2:0]       r_round;
    logic             r_done;
    logic             r_err;

    // Milestone FSM with registered event, clear, round and status outputs.
    // The event pulse and clear request default low every cycle. The event id
    // keeps its last value, so consumers must qualify it with the event pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_START;
            r_ctr_clr <= 1'b0;
            r_evt     <= 1'b0;
            r_evt_id  <= 4'd0;
            r_round   <= 3'd0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_evt     <= 1'b0;
            r_ctr_clr <= 1'b0;
            case (r_state)
                S_START: begin
                    r_evt    <= 1'b1;
                    r_evt_id <= EVT_START;
                    r_state  <= S_WAIT_A;
                end
                S_WAIT_A: begin
                    if (i_ctr_in == L_THR_A) begin
                        r_evt    <= 1'b1;
                        r_evt_id <= milestoneId(r_round, EVT_A_OFS);
                        r_state  <= S_WAIT_B;
                    end else if (i_ctr_in > L_THR_A) begin
                        r_err   <= 1'b1;
                        r_state <= S_ERR;
                    end
                end
                S_WAIT_B: begin
                    if (i_ctr_in == L_THR_B) begin
                        r_evt     <= 1'b1;
                        r_evt_id  <= milestoneId(r_round, EVT_B_OFS);
                        r_ctr_clr <= 1'b1;
                        if (r_round == L_LAST_ROUND) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_round <= r_round + 3'd1;
                            r_state <= S_SKIP;
                        end
                    end else if (i_ctr_in > L_THR_B) begin
                        r_err   <= 1'b1;
                        r_state <= S_ERR;
                    end
                end
                S_SKIP: begin
                    // The counter still shows its pre-clear value in this cycle.
                    r_state <= S_WAIT_A;
                end
                S_DONE:  r_state <= S_DONE;
                S_ERR:   r_state <= S_ERR;
                default: r_state <= S_ERR;
            endcase
        end
    end

    assign o_ctr_clr = r_ctr_clr;
    assign o_evt     = r_evt;
    assign o_evt_id  = r_evt_id;
    assign o_round   = r_round;
    assign o_done    = r_done;
    assign o_err     = r_err;

endmodule

// File: tb/tb_ctr_phase_sequencer.sv
// Directed bench for the counter phase sequencer. It drives three
// configurations: the defaults, a short single round, and a 4-bit wrapping counter.
// Observed outputs are packed as {evt, evt_id[3:0], ctr_clr, round[2:0], done, err}.
module tb_ctr_phase_sequencer;

    logic clk = 1'b0;

    // Free-running bench clock
    always #5 clk = ~clk;

    logic        rst0 = 1'b1;
    logic        rst1 = 1'b1;
    logic        rst2 = 1'b1;
    logic [31:0] ctr0 = 32'd0;
    logic [31:0] ctr1 = 32'd0;
    logic [3:0]  ctr2 = 4'd0;

    logic       clr0, evt0, done0, err0;
    logic [3:0] id0;
    logic [2:0] round0;
    logic       clr1, evt1, done1, err1;
    logic [3:0] id1;
    logic [2:0] round1;
    logic       clr2, evt2, done2, err2;
    logic [3:0] id2;
    logic [2:0] round2;

    logic [10:0] obs0, obs1, obs2;
    assign obs0 = {evt0, id0, clr0, round0, done0, err0};
    assign obs1 = {evt1, id1, clr1, round1, done1, err1};
    assign obs2 = {evt2, id2, clr2, round2, done2, err2};

    int checkCount = 0;
    int errorCount = 0;

    ctr_phase_sequencer dut0 (
        .i_clk(clk), .i_rst_n(rst0), .i_ctr_in(ctr0),
        .o_ctr_clr(clr0), .o_evt(evt0), .o_evt_id(id0),
        .o_round(round0), .o_done(done0), .o_err(err0)
    );

    ctr_phase_sequencer #(.CNT_W(32), .THR_A(0), .THR_B(1), .ROUNDS(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst1), .i_ctr_in(ctr1),
        .o_ctr_clr(clr1), .o_evt(evt1), .o_evt_id(id1),
        .o_round(round1), .o_done(done1), .o_err(err1)
    );

    ctr_phase_sequencer #(.CNT_W(4), .THR_A(14), .THR_B(15), .ROUNDS(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst2), .i_ctr_in(ctr2),
        .o_ctr_clr(clr2), .o_evt(evt2), .o_evt_id(id2),
        .o_round(round2), .o_done(done2), .o_err(err2)
    );

    function automatic logic [10:0] expv(input logic e, input int id, input logic c,
                                         input int r, input logic d, input logic er);
        return {e, 4'(id), c, 3'(r), d, er};
    endfunction

    // Present one counter value to the selected DUT, then let one edge sample it.
    task automatic applyStimulus(input int sel, input logic [31:0] v);
        @(negedge clk);
        case (sel)
            0:       ctr0 = v;
            1:       ctr1 = v;
            default: ctr2 = v[3:0];
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int sel, input logic [10:0] expected);
        logic [10:0] observed;
        observed = (sel == 0) ? obs0 : ((sel == 1) ? obs1 : obs2);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic step(input string tag, input int sel, input int v, input logic [10:0] expected);
        applyStimulus(sel, 32'(v));
        checkOutput(tag, sel, expected);
    endtask

    task automatic span(input string tag, input int sel, input int lo, input int hi,
                        input logic [10:0] expected);
        for (int v = lo; v <= hi; v++) begin
            step(tag, sel, v, expected);
        end
    endtask

    // Assert dut0 reset between edges, check the outputs before any edge, then release.
    task automatic pulseReset0(input string tag);
        #2 rst0 = 1'b0;
        #1 checkOutput(tag, 0, expv(0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #3 rst0 = 1'b1;
    endtask

    // Drive dut0 from release up to the id-4 event in round 1.
    task automatic runToRound1A(input string tag);
        step({tag, " start"}, 0, 0, expv(1, 1, 0, 0, 0, 0));
        step({tag, " pre A"}, 0, 1, expv(0, 1, 0, 0, 0, 0));
        step({tag, " id2"}, 0, 2, expv(1, 2, 0, 0, 0, 0));
        span({tag, " wait B0"}, 0, 3, 9, expv(0, 2, 0, 0, 0, 0));
        step({tag, " id3 clr"}, 0, 10, expv(1, 3, 1, 1, 0, 0));
        step({tag, " skip"}, 0, 11, expv(0, 3, 0, 1, 0, 0));
        span({tag, " wait A1"}, 0, 0, 1, expv(0, 3, 0, 1, 0, 0));
        step({tag, " id4"}, 0, 2, expv(1, 4, 0, 1, 0, 0));
    endtask

    // Directed sequence
    initial begin
        $display("[TB] start");
        #1;
        rst0 = 1'b0;
        rst1 = 1'b0;
        rst2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset dut0", 0, expv(0, 0, 0, 0, 0, 0));
        checkOutput("reset dut1", 1, expv(0, 0, 0, 0, 0, 0));
        checkOutput("reset dut2", 2, expv(0, 0, 0, 0, 0, 0));

        // Default run: counter from 0, cleared after each B milestone
        #2 rst0 = 1'b1;
        runToRound1A("t1");
        span("t1 wait B1", 0, 3, 9, expv(0, 4, 0, 1, 0, 0));
        step("t1 id5 done", 0, 10, expv(1, 5, 1, 1, 1, 0));
        step("t1 done hold a", 0, 11, expv(0, 5, 0, 1, 1, 0));
        step("t1 done hold b", 0, 0, expv(0, 5, 0, 1, 1, 0));
        step("t1 done hold c", 0, 2, expv(0, 5, 0, 1, 1, 0));
        pulseReset0("t1 async reset from done");

        // Reset while waiting for B in round 1, then restart
        runToRound1A("t5");
        span("t5 wait B1", 0, 3, 5, expv(0, 4, 0, 1, 0, 0));
        pulseReset0("t5 async reset mid round");

        // Restart, then jump 1 -> 5 in round 0
        step("t2 restart id1", 0, 0, expv(1, 1, 0, 0, 0, 0));
        step("t2 pre jump", 0, 1, expv(0, 1, 0, 0, 0, 0));
        step("t2 overshoot A", 0, 5, expv(0, 1, 0, 0, 0, 1));
        step("t2 frozen a", 0, 2, expv(0, 1, 0, 0, 0, 1));
        step("t2 frozen b", 0, 10, expv(0, 1, 0, 0, 0, 1));
        pulseReset0("t2 async reset from err");

        // Clear request ignored by the counter: overshoot after the skip cycle
        step("t4 start", 0, 0, expv(1, 1, 0, 0, 0, 0));
        step("t4 pre A", 0, 1, expv(0, 1, 0, 0, 0, 0));
        step("t4 id2", 0, 2, expv(1, 2, 0, 0, 0, 0));
        span("t4 wait B0", 0, 3, 9, expv(0, 2, 0, 0, 0, 0));
        step("t4 id3 clr", 0, 10, expv(1, 3, 1, 1, 0, 0));
        step("t4 skip", 0, 11, expv(0, 3, 0, 1, 0, 0));
        step("t4 overshoot A", 0, 12, expv(0, 3, 0, 1, 0, 1));
        step("t4 frozen", 0, 2, expv(0, 3, 0, 1, 0, 1));

        // Single round, A=0, B=1
        #2 rst1 = 1'b1;
        step("t3 start", 1, 0, expv(1, 1, 0, 0, 0, 0));
        step("t3 id2", 1, 0, expv(1, 2, 0, 0, 0, 0));
        step("t3 id3 done", 1, 1, expv(1, 3, 1, 0, 1, 0));
        step("t3 done hold a", 1, 1, expv(0, 3, 0, 0, 1, 0));
        step("t3 done hold b", 1, 0, expv(0, 3, 0, 0, 1, 0));

        // 4-bit counter, A=14, B=15, no clear: wraps 15 -> 0
        #2 rst2 = 1'b1;
        step("t6 start", 2, 0, expv(1, 1, 0, 0, 0, 0));
        span("t6 wait A0", 2, 1, 13, expv(0, 1, 0, 0, 0, 0));
        step("t6 id2", 2, 14, expv(1, 2, 0, 0, 0, 0));
        step("t6 id3 clr", 2, 15, expv(1, 3, 1, 1, 0, 0));
        step("t6 skip wrap", 2, 0, expv(0, 3, 0, 1, 0, 0));
        span("t6 wait A1", 2, 1, 13, expv(0, 3, 0, 1, 0, 0));
        step("t6 id4", 2, 14, expv(1, 4, 0, 1, 0, 0));
        step("t6 id5 done", 2, 15, expv(1, 5, 1, 1, 1, 0));
        step("t6 done hold", 2, 0, expv(0, 5, 0, 1, 1, 0));

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
